// File: rtl/addsub_pkg.sv
// Shared configuration for the pipelined adder/subtractor: default sizes,
// chunk-width helper and the legality check for a WIDTH/STAGES pair.
package addsub_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunkWidth(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit configOk(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CW-bit ripple-carry adder; one instance per pipeline stage so the
// longest combinational carry chain is a single chunk.
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    logic w_carry;

    always_comb begin
        w_carry = cin;
        sum     = '0;
        for (int i = 0; i < CW; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined chunked adder/subtractor with valid/ready on both sides. Chunk k
// is added in stage k; operands are skewed in, sums de-skewed out.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = chunkWidth(WIDTH, STAGES);

    if (!configOk(WIDTH, STAGES)) begin : g_badConfig
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic              w_adv;
    logic [WIDTH-1:0]  w_bEff;
    logic              w_cIn;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [STAGES-1:0] w_cout;
    logic [WIDTH-1:0]  w_sumNext;
    logic [WIDTH-1:0]  w_sumOut;
    logic              w_aMsb;
    logic              w_bMsb;
    logic              r_overflow;
    logic              r_zero;

    // The whole pipe moves as one; a full output slot that is not taken freezes everything.
    assign w_adv    = ~r_valid[STAGES-1] | OUT_READY;
    assign IN_READY = w_adv;
    assign w_bEff   = SUB ? ~B : B;
    assign w_cIn    = SUB ? ~CIN : CIN;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= '0;
            r_carry <= '0;
        end else if (w_adv) begin
            r_valid[0] <= IN_VALID;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            r_carry <= w_cout;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DSK = STAGES - 1 - k;

        logic [CW-1:0]        w_a;
        logic [CW-1:0]        w_b;
        logic [CW-1:0]        w_sum;
        logic                 w_ci;
        logic [DSK:0][CW-1:0] r_sumPipe;

        if (k == 0) begin : g_first
            assign w_a  = A[CW-1:0];
            assign w_b  = w_bEff[CW-1:0];
            assign w_ci = w_cIn;
        end else begin : g_skew
            logic [k-1:0][CW-1:0] r_aSkew;
            logic [k-1:0][CW-1:0] r_bSkew;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_aSkew <= '0;
                    r_bSkew <= '0;
                end else if (w_adv) begin
                    r_aSkew[0] <= A[k*CW +: CW];
                    r_bSkew[0] <= w_bEff[k*CW +: CW];
                    for (int j = 1; j < k; j++) begin
                        r_aSkew[j] <= r_aSkew[j-1];
                        r_bSkew[j] <= r_bSkew[j-1];
                    end
                end
            end

            assign w_a  = r_aSkew[k-1];
            assign w_b  = r_bSkew[k-1];
            assign w_ci = r_carry[k-1];
        end

        addsub_chunk #(.CW(CW)) u_chunk (
            .a    (w_a),
            .b    (w_b),
            .cin  (w_ci),
            .sum  (w_sum),
            .cout (w_cout[k])
        );

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_sumPipe <= '0;
            end else if (w_adv) begin
                r_sumPipe[0] <= w_sum;
                for (int j = 1; j <= DSK; j++) begin
                    r_sumPipe[j] <= r_sumPipe[j-1];
                end
            end
        end

        assign w_sumOut[k*CW +: CW] = r_sumPipe[DSK];

        // w_sumNext is what the output register of this chunk loads on the next advance.
        if (DSK == 0) begin : g_noDeskew
            assign w_sumNext[k*CW +: CW] = w_sum;
        end else begin : g_deskew
            assign w_sumNext[k*CW +: CW] = r_sumPipe[DSK-1];
        end

        if (k == STAGES - 1) begin : g_last
            assign w_aMsb = w_a[CW-1];
            assign w_bMsb = w_b[CW-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_adv) begin
            r_overflow <= (w_aMsb == w_bMsb) && (w_sumNext[WIDTH-1] != w_aMsb);
            r_zero     <= ~|w_sumNext;
        end
    end

    assign SUM       = w_sumOut;
    assign CARRY     = r_carry[STAGES-1];
    assign OVERFLOW  = r_overflow;
    assign ZERO      = r_zero;
    assign OUT_VALID = r_valid[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: arithmetic vectors, backpressure stream
// and mid-flight reset across 4-, 1- and 16-stage builds.
module tb_pipelined_addsub;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] A;
    logic [15:0] B;
    logic        CIN;
    logic        SUB;
    logic        IN_VALID;
    logic        OUT_READY;

    logic        inReady  [3];
    logic        outValid [3];
    logic        carryO   [3];
    logic        ovfO     [3];
    logic        zeroO    [3];
    logic [15:0] sumO     [3];

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    always #5 CLK = ~CLK;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .IN_VALID(IN_VALID), .IN_READY(inReady[0]), .SUM(sumO[0]), .CARRY(carryO[0]),
        .OVERFLOW(ovfO[0]), .ZERO(zeroO[0]), .OUT_VALID(outValid[0]), .OUT_READY(OUT_READY)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .IN_VALID(IN_VALID), .IN_READY(inReady[1]), .SUM(sumO[1]), .CARRY(carryO[1]),
        .OVERFLOW(ovfO[1]), .ZERO(zeroO[1]), .OUT_VALID(outValid[1]), .OUT_READY(OUT_READY)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(16)) u_dut16 (
        .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .IN_VALID(IN_VALID), .IN_READY(inReady[2]), .SUM(sumO[2]), .CARRY(carryO[2]),
        .OVERFLOW(ovfO[2]), .ZERO(zeroO[2]), .OUT_VALID(outValid[2]), .OUT_READY(OUT_READY)
    );

    // Flat reference: {ZERO, OVERFLOW, CARRY, SUM} straight from the arithmetic definition.
    function automatic logic [18:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [15:0] be;
        logic        ci;
        logic [16:0] r;
        logic        v;
        be = sub ? ~b : b;
        ci = sub ? ~cin : cin;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, ci};
        v  = (a[15] == be[15]) && (r[15] != a[15]);
        return {(r[15:0] == 16'h0000), v, r[16], r[15:0]};
    endfunction

    function automatic logic [31:0] packOut(input int j);
        return {13'b0, zeroO[j], ovfO[j], carryO[j], sumO[j]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic valid);
        A        = a;
        B        = b;
        CIN      = cin;
        SUB      = sub;
        IN_VALID = valid;
    endtask

    // One beat into the 4-stage build, then latency and every flag against hand values.
    task automatic runVector(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub, input logic [18:0] exp);
        int lat;
        applyStimulus(a, b, cin, sub, 1'b1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 0;
        while (!outValid[0] && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
        checkOutput({tag, "_sum"}, 32'(sumO[0]), 32'(exp[15:0]));
        checkOutput({tag, "_carry"}, 32'(carryO[0]), 32'(exp[16]));
        checkOutput({tag, "_overflow"}, 32'(ovfO[0]), 32'(exp[17]));
        checkOutput({tag, "_zero"}, 32'(zeroO[0]), 32'(exp[18]));
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        logic [18:0] expQ [8];
        int          sent;
        int          recv;
        bit          inAcc;
        bit          outAcc;
        bit          sawValid;
        int          expLat [3];
        int          lat [3];
        logic [15:0] got [3];

        expLat[0] = 3;
        expLat[1] = 0;
        expLat[2] = 15;

        RST_N     = 1'b1;
        OUT_READY = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        #1 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_out_valid", 32'(outValid[0]), 32'd0);
        checkOutput("reset_flags_sum", packOut(0), 32'd0);
        checkOutput("reset_in_ready", 32'(inReady[0]), 32'd1);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        runVector("add_basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h0100});
        runVector("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
        runVector("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
        runVector("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF});
        runVector("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});

        for (int i = 0; i < 8; i++) begin
            va[i]   = 16'($urandom);
            vb[i]   = 16'($urandom);
            vc[i]   = 1'($urandom_range(0, 1));
            vs[i]   = 1'($urandom_range(0, 1));
            expQ[i] = refModel(va[i], vb[i], vc[i], vs[i]);
        end
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            OUT_READY = !(cyc >= 5 && cyc <= 7);
            if (sent < 8) applyStimulus(va[sent], vb[sent], vc[sent], vs[sent], 1'b1);
            else IN_VALID = 1'b0;
            #1;
            if (cyc >= 5 && cyc <= 7) checkOutput("stall_in_ready", 32'(inReady[0]), 32'd0);
            inAcc  = IN_VALID && inReady[0];
            outAcc = outValid[0] && OUT_READY;
            if (outValid[0]) begin
                if (recv < 8) checkOutput($sformatf("stream_beat%0d", recv), packOut(0), 32'(expQ[recv]));
                else checkOutput("stream_extra_beat", 32'(outValid[0]), 32'd0);
            end
            @(posedge CLK); #1;
            if (inAcc) sent++;
            if (outAcc) recv++;
        end
        checkOutput("stream_count", 32'(recv), 32'd8);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        sawValid  = 1'b0;
        repeat (5) begin
            if (outValid[0]) sawValid = 1'b1;
            @(posedge CLK); #1;
        end
        checkOutput("stream_no_duplicate", 32'(sawValid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h1000 + 16'(i), 16'h0001, 1'b0, 1'b0, 1'b1);
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        #3 RST_N = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("midreset_out_valid_%0d", j), 32'(outValid[j]), 32'd0);
            checkOutput($sformatf("midreset_sum_%0d", j), 32'(sumO[j]), 32'd0);
        end
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;
        for (int j = 0; j < 3; j++) lat[j] = -1;
        sawValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < 3; j++) if (outValid[j]) lat[j] = -2;
            @(posedge CLK); #1;
        end
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("midreset_no_ghost_%0d", j), 32'(lat[j]), 32'hFFFF_FFFF);
            lat[j] = -1;
            got[j] = 16'h0000;
        end

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int j = 0; j < 3; j++) begin
                if (lat[j] < 0 && outValid[j]) begin
                    lat[j] = c;
                    got[j] = sumO[j];
                end
            end
            @(posedge CLK); #1;
        end
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("after_reset_latency_%0d", j), 32'(lat[j]), 32'(expLat[j]));
            checkOutput($sformatf("after_reset_sum_%0d", j), 32'(got[j]), 32'h2345);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined ripple-chunk adder/subtractor. It is the next-generation replacement for the fixed 4-bit parallel adder. The datapath is WIDTH bits, split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages. It sits between operand producers and result consumers, with valid/ready handshakes on both sides, and adds subtract mode plus carry, signed-overflow and zero flags.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of chunks; 1 ≤ STAGES ≤ WIDTH.

Ports. Clock is CLK, reset is RST_N: one clock, asynchronous active-low reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in (add) / borrow-in (sub).
- SUB  in  1  0 = A+B+CIN, 1 = A−B−CIN.
- IN_VALID  in  1  operand beat valid.
- IN_READY  out  1  block can accept a beat.
- SUM  out  WIDTH  result.
- CARRY  out  1  final carry-out; in sub mode 1 = no borrow.
- OVERFLOW  out  1  two's-complement overflow.
- ZERO  out  1  SUM == 0.
- OUT_VALID  out  1  result beat valid.
- OUT_READY  in  1  consumer accepts result.

## Operation
- Chunk width CW = WIDTH/STAGES. Stage k (0..STAGES−1) adds bits [k*CW +: CW].
- Effective operand: B_eff = SUB ? ~B : B. Effective carry-in: c_in = SUB ? ~CIN : CIN. This gives A + ~B + 1 − CIN.
- Stage 0 adds A/B_eff chunk 0 with c_in.
- Stage k adds chunk k with the carry registered by stage k−1.
- Upper operand chunks are skewed, i.e. delayed k registers, before stage k.
- Lower sum chunks are de-skewed, i.e. delayed STAGES−1−k registers, so all SUM bits of one beat emerge together.
- CARRY = carry-out of the last chunk.
- OVERFLOW = (A[WIDTH−1] == B_eff[WIDTH−1]) && (SUM[WIDTH−1] != A[WIDTH−1]). It is computed in the last stage from the delayed MSBs.
- ZERO = ~|SUM, registered with SUM; it is not recomputed combinationally at the output.
- Each stage holds a valid bit. A beat is accepted when IN_VALID && IN_READY.
- Global advance: adv = ~OUT_VALID | OUT_READY.
  - IN_READY = adv. This is a purely combinational path from OUT_READY.
  - When adv = 0, all stage registers, skew/de-skew registers and valid bits hold.
  - When adv = 1, everything shifts one stage. Stage 0 valid loads IN_VALID.
- Bubbles propagate as invalid slots; no compaction.
- Reset: every valid bit is cleared; SUM, CARRY, OVERFLOW, ZERO, OUT_VALID = 0. Datapath registers are also cleared, so there is no X on outputs.
- Reset mid-operation discards all in-flight beats. The first beat accepted after RST_N deasserts behaves as from idle.
- Simultaneous output accept and input accept in one cycle is legal and required; this is full throughput.

## Timing
- Latency: a beat accepted at edge t appears on outputs with OUT_VALID = 1 after edge t+STAGES−1 when unstalled. STAGES = 1 gives a single registered stage.
- Throughput: 1 beat/cycle while OUT_READY = 1.
- Output stability: while OUT_VALID && !OUT_READY, SUM/CARRY/OVERFLOW/ZERO must not change.
- Critical path: one CW-bit ripple plus the carry-register setup; no WIDTH-wide ripple.
- IN_READY may depend combinationally on OUT_READY; no other input-to-output combinational path.

## Structure
- Shared package `addsub_pkg`:
  - default WIDTH/STAGES constants;
  - a function computing CW;
  - the elaboration check that WIDTH % STAGES == 0, which must fail synthesis or elaboration otherwise.
- One sub-module `addsub_chunk`: a CW-bit ripple adder with inputs a, b, cin and outputs sum, cout. It is instantiated STAGES times via generate. The existing full_adder cell may be reused inside it.
- Skew and de-skew shift registers are generated inside the top module.

## Test plan
Default WIDTH = 16, STAGES = 4 unless noted.
- Add: A=0x00FF, B=0x0001, CIN=0, SUB=0 → SUM=0x0100, CARRY=0, OVERFLOW=0, ZERO=0. OUT_VALID is exactly 3 cycles after accept, i.e. STAGES−1 edges after the accepting edge.
- Full carry chain across all chunks: A=0xFFFF, B=0x0000, CIN=1 → SUM=0x0000, CARRY=1, ZERO=1, OVERFLOW=0.
- Subtract: A=0x0005, B=0x0007, CIN=0, SUB=1 → SUM=0xFFFE, CARRY=0 (borrow), OVERFLOW=0. Then A=0x8000, B=0x0001, SUB=1 → SUM=0x7FFF, OVERFLOW=1.
- Signed overflow add: A=0x7FFF, B=0x0001 → SUM=0x8000, OVERFLOW=1, CARRY=0.
- Backpressure: stream 8 random beats with IN_VALID=1, holding OUT_READY=0 for 3 cycles mid-stream.
  - All 8 results arrive in order, match the reference model, and none are lost or duplicated.
  - Outputs are held stable while stalled.
  - IN_READY=0 during the stall.
- Reset mid-flight: accept 3 beats, pulse RST_N low asynchronously between edges.
  - OUT_VALID=0 and SUM=0 immediately.
  - None of the 3 beats ever appears.
  - A new beat after release (0x1234+0x1111) gives SUM=0x2345 at the nominal latency.
  - Repeat this scenario with STAGES=1 and STAGES=16.
